// File: rtl/multi_src_reg_if.sv
// Bus bundle for multi_src_reg: per-source write ports in, register value and
// conflict status out. master drives the writes, slave is the register.
interface multi_src_reg_if #(
    parameter int WIDTH = 8,
    parameter int NSRC  = 2,
    parameter int CNT_W = 8
);
    localparam int SRC_W = (NSRC > 1) ? $clog2(NSRC) : 1;

    logic [NSRC-1:0]       wr_en;
    logic [NSRC*WIDTH-1:0] wr_mask;
    logic [NSRC*WIDTH-1:0] wr_data;
    logic                  clr_status;
    logic [WIDTH-1:0]      q;
    logic                  conflict;
    logic                  conflict_sticky;
    logic [WIDTH-1:0]      conflict_bits;
    logic [CNT_W-1:0]      conflict_cnt;
    logic                  first_valid;
    logic [SRC_W-1:0]      first_lo;
    logic [SRC_W-1:0]      first_hi;

    modport master (
        output wr_en, wr_mask, wr_data, clr_status,
        input  q, conflict, conflict_sticky, conflict_bits, conflict_cnt,
               first_valid, first_lo, first_hi
    );

    modport slave (
        input  wr_en, wr_mask, wr_data, clr_status,
        output q, conflict, conflict_sticky, conflict_bits, conflict_cnt,
               first_valid, first_lo, first_hi
    );
endinterface

// File: rtl/multi_src_reg.sv
// Register shared by NSRC masked writers with priority resolution and overlap
// reporting. The first-conflict record is built only with MSR_CONFLICT_LOG_EN.
module multi_src_reg #(
    parameter int WIDTH     = 8,
    parameter int NSRC      = 2,
    parameter bit LAST_WINS = 1'b1,
    parameter int CNT_W     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    multi_src_reg_if.slave      bus
);
    localparam int SRC_W = (NSRC > 1) ? $clog2(NSRC) : 1;

    logic [WIDTH-1:0] em [NSRC];
    logic [WIDTH-1:0] seen;
    logic [WIDTH-1:0] contested;
    logic [WIDTH-1:0] q_next;
    logic             any_conflict;

    logic [WIDTH-1:0] q_r;
    logic             conflict_r;
    logic             sticky_r;
    logic [WIDTH-1:0] bits_r;
    logic [CNT_W-1:0] cnt_r;

    // A bit is contested once a second source's effective mask hits it.
    always_comb begin
        seen      = '0;
        contested = '0;
        q_next    = q_r;
        for (int s = 0; s < NSRC; s++) begin
            em[s]     = bus.wr_mask[s*WIDTH +: WIDTH] & {WIDTH{bus.wr_en[s]}};
            contested = contested | (seen & em[s]);
            seen      = seen | em[s];
        end
        // Later writes in loop order override earlier ones, so iteration order sets priority.
        if (LAST_WINS) begin
            for (int s = 0; s < NSRC; s++)
                q_next = (q_next & ~em[s]) | (bus.wr_data[s*WIDTH +: WIDTH] & em[s]);
        end else begin
            for (int s = NSRC - 1; s >= 0; s--)
                q_next = (q_next & ~em[s]) | (bus.wr_data[s*WIDTH +: WIDTH] & em[s]);
        end
    end

    assign any_conflict = |contested;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r        <= '0;
            conflict_r <= 1'b0;
            sticky_r   <= 1'b0;
            bits_r     <= '0;
            cnt_r      <= '0;
        end else begin
            q_r        <= q_next;
            conflict_r <= any_conflict;
            // Clear takes effect before this cycle's overlap is folded in.
            if (bus.clr_status) begin
                sticky_r <= any_conflict;
                bits_r   <= contested;
                cnt_r    <= any_conflict ? CNT_W'(1) : '0;
            end else if (any_conflict) begin
                sticky_r <= 1'b1;
                bits_r   <= bits_r | contested;
                if (cnt_r != {CNT_W{1'b1}})
                    cnt_r <= cnt_r + 1'b1;
            end
        end
    end

`ifdef MSR_CONFLICT_LOG_EN
    logic             fv_r;
    logic [SRC_W-1:0] lo_r;
    logic [SRC_W-1:0] hi_r;
    logic [SRC_W-1:0] lo_c;
    logic [SRC_W-1:0] hi_c;
    logic             found;

    always_comb begin
        lo_c  = '0;
        hi_c  = '0;
        found = 1'b0;
        for (int s = 0; s < NSRC; s++) begin
            if (|(em[s] & contested)) begin
                if (!found)
                    lo_c = SRC_W'(s);
                found = 1'b1;
                hi_c  = SRC_W'(s);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fv_r <= 1'b0;
            lo_r <= '0;
            hi_r <= '0;
        end else if (bus.clr_status || !fv_r) begin
            fv_r <= any_conflict;
            lo_r <= any_conflict ? lo_c : '0;
            hi_r <= any_conflict ? hi_c : '0;
        end
    end

    assign bus.first_valid = fv_r;
    assign bus.first_lo    = lo_r;
    assign bus.first_hi    = hi_r;
`else
    assign bus.first_valid = 1'b0;
    assign bus.first_lo    = '0;
    assign bus.first_hi    = '0;
`endif

    assign bus.q               = q_r;
    assign bus.conflict        = conflict_r;
    assign bus.conflict_sticky = sticky_r;
    assign bus.conflict_bits   = bits_r;
    assign bus.conflict_cnt    = cnt_r;
endmodule

// File: tb/tb_multi_src_reg.sv
// Directed vector bench for multi_src_reg: two instances (last-wins with a
// 2-bit counter, first-wins with an 8-bit counter) driven with identical writes.
module tb_multi_src_reg;
    localparam int WIDTH = 8;
    localparam int NSRC  = 2;
`ifdef MSR_CONFLICT_LOG_EN
    localparam bit LOG_EN = 1'b1;
`else
    localparam bit LOG_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    multi_src_reg_if #(.WIDTH(WIDTH), .NSRC(NSRC), .CNT_W(2)) ifa ();
    multi_src_reg_if #(.WIDTH(WIDTH), .NSRC(NSRC), .CNT_W(8)) ifb ();

    multi_src_reg #(.WIDTH(WIDTH), .NSRC(NSRC), .LAST_WINS(1'b1), .CNT_W(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    multi_src_reg #(.WIDTH(WIDTH), .NSRC(NSRC), .LAST_WINS(1'b0), .CNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb.slave));

    typedef struct {
        logic [1:0] en;
        logic [7:0] m0, d0, m1, d1;
        logic       clr;
        logic [7:0] qa, qb;
        logic       conf, sticky;
        logic [7:0] bits;
        logic [7:0] cnta, cntb;
        logic       fv, lo, hi;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] en, input logic [7:0] m0, input logic [7:0] d0,
                         input logic [7:0] m1, input logic [7:0] d1, input logic clr);
        ifa.wr_en = en;  ifa.wr_mask = {m1, m0}; ifa.wr_data = {d1, d0}; ifa.clr_status = clr;
        ifb.wr_en = en;  ifb.wr_mask = {m1, m0}; ifb.wr_data = {d1, d0}; ifb.clr_status = clr;
    endtask

    task automatic check_all(input string tag, input vec_t v);
        check({tag, " q_a"}, 64'(ifa.q), 64'(v.qa));
        check({tag, " q_b"}, 64'(ifb.q), 64'(v.qb));
        check({tag, " conflict_a"}, 64'(ifa.conflict), 64'(v.conf));
        check({tag, " conflict_b"}, 64'(ifb.conflict), 64'(v.conf));
        check({tag, " sticky_a"}, 64'(ifa.conflict_sticky), 64'(v.sticky));
        check({tag, " sticky_b"}, 64'(ifb.conflict_sticky), 64'(v.sticky));
        check({tag, " bits_a"}, 64'(ifa.conflict_bits), 64'(v.bits));
        check({tag, " bits_b"}, 64'(ifb.conflict_bits), 64'(v.bits));
        check({tag, " cnt_a"}, 64'(ifa.conflict_cnt), 64'(v.cnta));
        check({tag, " cnt_b"}, 64'(ifb.conflict_cnt), 64'(v.cntb));
        check({tag, " first_valid_a"}, 64'(ifa.first_valid), 64'(v.fv & LOG_EN));
        check({tag, " first_lo_a"}, 64'(ifa.first_lo), 64'(v.lo & LOG_EN));
        check({tag, " first_hi_a"}, 64'(ifa.first_hi), 64'(v.hi & LOG_EN));
        check({tag, " first_valid_b"}, 64'(ifb.first_valid), 64'(v.fv & LOG_EN));
        check({tag, " first_hi_b"}, 64'(ifb.first_hi), 64'(v.hi & LOG_EN));
    endtask

    initial begin
        //          en     m0     d0     m1     d1    clr   qa     qb    cf st  bits  cnta  cntb  fv lo hi
        vecs[0]  = '{2'b11, 8'h0F, 8'hAA, 8'hF8, 8'h55, 1'b0, 8'h52, 8'h5A, 1, 1, 8'h08, 8'd1, 8'd1, 1, 0, 1};
        vecs[1]  = '{2'b11, 8'h0F, 8'h03, 8'hF0, 8'h30, 1'b1, 8'h33, 8'h33, 0, 0, 8'h00, 8'd0, 8'd0, 0, 0, 0};
        vecs[2]  = '{2'b11, 8'h0F, 8'h05, 8'hF0, 8'hC0, 1'b0, 8'hC5, 8'hC5, 0, 0, 8'h00, 8'd0, 8'd0, 0, 0, 0};
        vecs[3]  = '{2'b01, 8'hF0, 8'hA0, 8'hFF, 8'h00, 1'b0, 8'hA5, 8'hA5, 0, 0, 8'h00, 8'd0, 8'd0, 0, 0, 0};
        vecs[4]  = '{2'b00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 8'hA5, 8'hA5, 0, 0, 8'h00, 8'd0, 8'd0, 0, 0, 0};
        vecs[5]  = vecs[4];
        vecs[6]  = vecs[4];
        vecs[7]  = '{2'b11, 8'hFF, 8'h11, 8'hFF, 8'h22, 1'b0, 8'h22, 8'h11, 1, 1, 8'hFF, 8'd1, 8'd1, 1, 0, 1};
        vecs[8]  = '{2'b11, 8'hFF, 8'h11, 8'hFF, 8'h22, 1'b0, 8'h22, 8'h11, 1, 1, 8'hFF, 8'd2, 8'd2, 1, 0, 1};
        vecs[9]  = '{2'b11, 8'hFF, 8'h11, 8'hFF, 8'h22, 1'b0, 8'h22, 8'h11, 1, 1, 8'hFF, 8'd3, 8'd3, 1, 0, 1};
        vecs[10] = '{2'b11, 8'hFF, 8'h11, 8'hFF, 8'h22, 1'b0, 8'h22, 8'h11, 1, 1, 8'hFF, 8'd3, 8'd4, 1, 0, 1};
        vecs[11] = '{2'b11, 8'hFF, 8'h11, 8'hFF, 8'h22, 1'b0, 8'h22, 8'h11, 1, 1, 8'hFF, 8'd3, 8'd5, 1, 0, 1};
        vecs[12] = '{2'b11, 8'h08, 8'h08, 8'h08, 8'h00, 1'b1, 8'h22, 8'h19, 1, 1, 8'h08, 8'd1, 8'd1, 1, 0, 1};
        vecs[13] = '{2'b11, 8'h01, 8'h01, 8'h01, 8'h00, 1'b1, 8'h22, 8'h19, 1, 1, 8'h01, 8'd1, 8'd1, 1, 0, 1};
        vecs[14] = '{2'b11, 8'h0F, 8'hAA, 8'hF8, 8'h55, 1'b0, 8'h52, 8'h5A, 1, 1, 8'h09, 8'd2, 8'd2, 1, 0, 1};

        drive(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        #12;
        check_all("reset", '{2'b00, 8'h0, 8'h0, 8'h0, 8'h0, 1'b0, 8'h00, 8'h00, 0, 0, 8'h00, 8'd0, 8'd0, 0, 0, 0});
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].en, vecs[i].m0, vecs[i].d0, vecs[i].m1, vecs[i].d1, vecs[i].clr);
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i]);
        end

        // Asynchronous reset between edges with q=0x52 and sticky set.
        drive(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", '{2'b00, 8'h0, 8'h0, 8'h0, 8'h0, 1'b0, 8'h00, 8'h00, 0, 0, 8'h00, 8'd0, 8'd0, 0, 0, 0});
        @(negedge clk);
        rst_n = 1'b1;

        // First edge after release samples normally; nothing from before reset survives.
        drive(2'b10, 8'hFF, 8'hFF, 8'h0F, 8'h06, 1'b0);
        @(posedge clk);
        #1;
        check_all("post_rst", '{2'b10, 8'h0, 8'h0, 8'h0, 8'h0, 1'b0, 8'h06, 8'h06, 0, 0, 8'h00, 8'd0, 8'd0, 0, 0, 0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
